// File: rtl/fifo_sync_core_if.sv
// Handshake and status bundle between a FIFO driver/monitor and the fifo_sync_core responder.
interface fifo_sync_core_if #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] i_wrdata;
    logic              i_wren;
    logic              i_rden;
    logic [DATA_W-1:0] o_rddata;
    logic              o_full;
    logic              o_empty;
    logic              o_alm_full;
    logic              o_alm_empty;
    logic [CNT_W-1:0]  o_count;
    logic              o_overflow;
    logic              o_underflow;

    modport master (
        output i_wrdata, i_wren, i_rden,
        input  o_rddata, o_full, o_empty, o_alm_full, o_alm_empty,
               o_count, o_overflow, o_underflow
    );

    modport slave (
        input  i_wrdata, i_wren, i_rden,
        output o_rddata, o_full, o_empty, o_alm_full, o_alm_empty,
               o_count, o_overflow, o_underflow
    );
endinterface

// File: rtl/fifo_sync_core.sv
// Single-clock FIFO with registered read data, registered status flags,
// sticky overflow/underflow errors and an occupancy count.
module fifo_sync_core #(
    parameter int DATA_W        = 128,
    parameter int DEPTH         = 16,
    parameter int ALM_FULL_OFS  = 2,
    parameter int ALM_EMPTY_OFS = 2
) (
    input  logic             clk,
    input  logic             rst,
    fifo_sync_core_if.slave  fifo
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr_q;
    logic [PTR_W-1:0]  rptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_nxt;
    logic [DATA_W-1:0] rddata_q;
    logic              full_q;
    logic              empty_q;
    logic              alm_full_q;
    logic              alm_empty_q;
    logic              ovf_q;
    logic              unf_q;
    logic              wr_acc;
    logic              rd_acc;

    // Acceptance looks only at flags registered before the edge.
    always_comb begin
        wr_acc    = fifo.i_wren && !full_q;
        rd_acc    = fifo.i_rden && !empty_q;
        count_nxt = count_q;
        if (wr_acc && !rd_acc) begin
            count_nxt = count_q + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            count_nxt = count_q - CNT_W'(1);
        end
    end

    // Storage is not reset; its contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr_q] <= fifo.i_wrdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            rddata_q    <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            alm_full_q  <= 1'b0;
            alm_empty_q <= 1'b1;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            if (rd_acc) begin
                rptr_q   <= rptr_q + PTR_W'(1);
                rddata_q <= mem[rptr_q];
            end
            if (fifo.i_wren && full_q) begin
                ovf_q <= 1'b1;
            end
            if (fifo.i_rden && empty_q) begin
                unf_q <= 1'b1;
            end
            // Flags follow the next count so they line up with o_count.
            count_q     <= count_nxt;
            full_q      <= (count_nxt == CNT_W'(DEPTH));
            empty_q     <= (count_nxt == '0);
            alm_full_q  <= (count_nxt >= CNT_W'(DEPTH - ALM_FULL_OFS));
            alm_empty_q <= (count_nxt <= CNT_W'(ALM_EMPTY_OFS));
        end
    end

    assign fifo.o_rddata    = rddata_q;
    assign fifo.o_full      = full_q;
    assign fifo.o_empty     = empty_q;
    assign fifo.o_alm_full  = alm_full_q;
    assign fifo.o_alm_empty = alm_empty_q;
    assign fifo.o_count     = count_q;
    assign fifo.o_overflow  = ovf_q;
    assign fifo.o_underflow = unf_q;
endmodule

// File: tb/tb_fifo_sync_core.sv
// Self-checking bench for fifo_sync_core: vector table, directed corner cases
// and a random push/pop run checked against a queue-based reference model.
module tb_fifo_sync_core;
    localparam int DATA_W = 128;
    localparam int DEPTH  = 16;
    localparam int AF_OFS = 2;
    localparam int AE_OFS = 2;

    logic clk;
    logic rst;

    fifo_sync_core_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) fifo ();

    fifo_sync_core #(
        .DATA_W(DATA_W), .DEPTH(DEPTH),
        .ALM_FULL_OFS(AF_OFS), .ALM_EMPTY_OFS(AE_OFS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .fifo(fifo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain queue plus sticky flags and last-read word.
    logic [DATA_W-1:0] mq[$];
    logic [DATA_W-1:0] m_rd;
    bit                m_ovf;
    bit                m_unf;
    int unsigned       n_cmp;
    int unsigned       n_bad;
    int unsigned       n_wr;

    always @(posedge clk) begin
        if (rst) begin
            assert (!$isunknown(fifo.i_wren) && !$isunknown(fifo.i_rden))
                else $error("X on i_wren/i_rden");
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cmp(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_rd  = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // One clock cycle starting and ending at a falling edge.
    task automatic cyc(input bit wr, input bit rd, input logic [DATA_W-1:0] d);
        bit was_full;
        bit was_empty;
        fifo.i_wren   = wr;
        fifo.i_rden   = rd;
        fifo.i_wrdata = d;
        @(posedge clk);
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        if (wr && was_full)  m_ovf = 1'b1;
        if (rd && was_empty) m_unf = 1'b1;
        if (rd && !was_empty) m_rd = mq.pop_front();
        if (wr && !was_full) begin
            mq.push_back(d);
            n_wr++;
        end
        @(negedge clk);
        fifo.i_wren = 1'b0;
        fifo.i_rden = 1'b0;
    endtask

    task automatic check_model(input string tag);
        int unsigned n;
        n = mq.size();
        cmp({tag, ".count"},     DATA_W'(fifo.o_count),     DATA_W'(n));
        cmp({tag, ".full"},      DATA_W'(fifo.o_full),      DATA_W'(n == DEPTH));
        cmp({tag, ".empty"},     DATA_W'(fifo.o_empty),     DATA_W'(n == 0));
        cmp({tag, ".alm_full"},  DATA_W'(fifo.o_alm_full),  DATA_W'(n >= DEPTH - AF_OFS));
        cmp({tag, ".alm_empty"}, DATA_W'(fifo.o_alm_empty), DATA_W'(n <= AE_OFS));
        cmp({tag, ".overflow"},  DATA_W'(fifo.o_overflow),  DATA_W'(m_ovf));
        cmp({tag, ".underflow"}, DATA_W'(fifo.o_underflow), DATA_W'(m_unf));
        cmp({tag, ".rddata"},    fifo.o_rddata,             m_rd);
    endtask

    task automatic check_reset_vals(input string tag);
        cmp({tag, ".count"},     DATA_W'(fifo.o_count),     '0);
        cmp({tag, ".empty"},     DATA_W'(fifo.o_empty),     DATA_W'(1));
        cmp({tag, ".alm_empty"}, DATA_W'(fifo.o_alm_empty), DATA_W'(1));
        cmp({tag, ".full"},      DATA_W'(fifo.o_full),      '0);
        cmp({tag, ".alm_full"},  DATA_W'(fifo.o_alm_full),  '0);
        cmp({tag, ".rddata"},    fifo.o_rddata,             '0);
        cmp({tag, ".overflow"},  DATA_W'(fifo.o_overflow),  '0);
        cmp({tag, ".underflow"}, DATA_W'(fifo.o_underflow), '0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit                wr;
        bit                rd;
        logic [DATA_W-1:0] d;
        int unsigned       cnt;
        logic [DATA_W-1:0] rdata;
        bit                empty;
        bit                aempty;
        bit                unf;
    } vec_t;

    vec_t tbl[8];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        n_wr  = 0;
        rst   = 1'b0;
        fifo.i_wren   = 1'b0;
        fifo.i_rden   = 1'b0;
        fifo.i_wrdata = '0;

        tbl[0] = '{1'b1, 1'b0, 128'hA1, 1, 128'h0,  1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 128'hA2, 2, 128'h0,  1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 128'hA3, 3, 128'h0,  1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 128'h0,  2, 128'hA1, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 128'hA4, 2, 128'hA2, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 128'h0,  1, 128'hA3, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 128'h0,  0, 128'hA4, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 128'h0,  0, 128'hA4, 1'b1, 1'b1, 1'b1};

        @(negedge clk);
        do_reset();

        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].wr, tbl[i].rd, tbl[i].d);
            cmp($sformatf("tbl%0d.count", i),     DATA_W'(fifo.o_count),     DATA_W'(tbl[i].cnt));
            cmp($sformatf("tbl%0d.rddata", i),    fifo.o_rddata,             tbl[i].rdata);
            cmp($sformatf("tbl%0d.empty", i),     DATA_W'(fifo.o_empty),     DATA_W'(tbl[i].empty));
            cmp($sformatf("tbl%0d.alm_empty", i), DATA_W'(fifo.o_alm_empty), DATA_W'(tbl[i].aempty));
            cmp($sformatf("tbl%0d.underflow", i), DATA_W'(fifo.o_underflow), DATA_W'(tbl[i].unf));
        end

        do_reset();

        // Fill 0x1..0x10
        for (int i = 1; i <= DEPTH; i++) begin
            cyc(1'b1, 1'b0, DATA_W'(i));
            check_model($sformatf("fill%0d", i));
            cmp($sformatf("fill%0d.af_edge", i), DATA_W'(fifo.o_alm_full), DATA_W'(i >= 14));
            cmp($sformatf("fill%0d.f_edge", i),  DATA_W'(fifo.o_full),     DATA_W'(i == 16));
        end

        cyc(1'b1, 1'b0, 128'hDEAD);
        cmp("ovf.count", DATA_W'(fifo.o_count),    DATA_W'(16));
        cmp("ovf.flag",  DATA_W'(fifo.o_overflow), DATA_W'(1));
        check_model("ovf");

        cyc(1'b1, 1'b1, 128'hBEEF);
        cmp("full_wr_rd.count",  DATA_W'(fifo.o_count), DATA_W'(15));
        cmp("full_wr_rd.rddata", fifo.o_rddata,         DATA_W'(1));
        check_model("full_wr_rd");

        for (int i = 2; i <= DEPTH; i++) begin
            cyc(1'b0, 1'b1, '0);
            cmp($sformatf("drain%0d.rddata", i), fifo.o_rddata, DATA_W'(i));
            check_model($sformatf("drain%0d", i));
        end

        cyc(1'b0, 1'b1, '0);
        cmp("unf.rddata_hold", fifo.o_rddata,          DATA_W'(16));
        cmp("unf.flag",        DATA_W'(fifo.o_underflow), DATA_W'(1));
        cmp("unf.count",       DATA_W'(fifo.o_count),     '0);

        cyc(1'b1, 1'b1, 128'h77);
        cmp("empty_wr_rd.count", DATA_W'(fifo.o_count),  DATA_W'(1));
        cmp("empty_wr_rd.rddata", fifo.o_rddata,         DATA_W'(16));
        check_model("empty_wr_rd");

        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, DATA_W'(128'h100 + i));
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b1, {$urandom, $urandom, $urandom, $urandom});
            cmp($sformatf("steady%0d.count", i), DATA_W'(fifo.o_count), DATA_W'(5));
            check_model($sformatf("steady%0d", i));
        end

        // Random run kept within 1..15 entries
        for (int i = 0; i < 80; i++) begin
            bit wr;
            bit rd;
            wr = $urandom_range(0, 1);
            rd = $urandom_range(0, 1);
            if (mq.size() >= DEPTH - 1) wr = 1'b0;
            if (mq.size() <= 1)         rd = 1'b0;
            cyc(wr, rd, {$urandom, $urandom, $urandom, $urandom});
            check_model($sformatf("rnd%0d", i));
        end
        cmp("wrap.writes>=2*DEPTH", DATA_W'(n_wr >= 2 * DEPTH), DATA_W'(1));

        while (mq.size() != 7) begin
            if (mq.size() < 7) cyc(1'b1, 1'b0, DATA_W'($urandom));
            else               cyc(1'b0, 1'b1, '0);
        end
        check_model("pre_midreset");

        // Asynchronous reset mid-burst, checked before any clock edge
        fifo.i_wren   = 1'b1;
        fifo.i_wrdata = 128'h55;
        #2;
        rst = 1'b0;
        #1;
        check_reset_vals("midreset");
        fifo.i_wren = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        cyc(1'b1, 1'b0, 128'hC0FFEE);
        cyc(1'b0, 1'b1, '0);
        cmp("post_reset.rddata", fifo.o_rddata, 128'hC0FFEE);
        check_model("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
